// File: rtl/scroll_pkg.sv
// Shared scroll/camera definitions: FSM encodings, position width and the
// world-length bound used by the scroll, sprite and collision logic.
package scroll_pkg;

  localparam int POS_W = 14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UPDATE = 3'd1,
    S_START  = 3'd2,
    S_ACK    = 3'd3,
    S_DRAW   = 3'd4
  } scroll_state_e;

  // Rightmost camera position in pixels: the last screenful of tiles, 8 px each.
  function automatic int calc_max_pos(input int tilemap_length, input int screen_tiles);
    return (tilemap_length - screen_tiles) * 8;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame divider: tick is high for the one cycle in which the
// count sits at FRAME_DIV-1, then the count wraps to 0.
module frame_timer #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic tick
);

  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scroll_controller.sv
// Camera position register with per-frame clamped moves, plus the
// enable/done handshake that asks drawBackground to repaint the screen.
module scroll_controller
  import scroll_pkg::*;
#(
  parameter int TILEMAP_LENGTH = 2000,
  parameter int SCREEN_TILES   = 20,
  parameter int FRAME_DIV      = 833333,
  parameter int SPEED          = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        move_right,
  input  logic        move_left,
  input  logic        draw_done,
  output logic        draw_enable,
  output logic [10:0] x_tile_offset,
  output logic [2:0]  x_pixel_offset,
  output logic        busy,
  output logic        at_left_end,
  output logic        at_right_end,
  output logic        frame_overrun
);

  localparam int MAX_POS = calc_max_pos(TILEMAP_LENGTH, SCREEN_TILES);
  localparam logic [POS_W-1:0] MAX_POS_V = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0] SPEED_V   = POS_W'(SPEED);

  logic tick;

  frame_timer #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_timer (
    .clock (clock),
    .resetn(resetn),
    .tick  (tick)
  );

  scroll_state_e    state_q;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  logic             draw_enable_q;
  logic             busy_q;
  logic [POS_W:0]   pos_inc;

  // One extra bit on the sum so the right-hand clamp cannot be fooled by a carry.
  always_comb begin
    pos_inc = {1'b0, pos_q} + {1'b0, SPEED_V};
    pos_d   = pos_q;
    unique case ({move_right, move_left})
      2'b10:   pos_d = (pos_inc > {1'b0, MAX_POS_V}) ? MAX_POS_V : pos_inc[POS_W-1:0];
      2'b01:   pos_d = (pos_q < SPEED_V) ? '0 : pos_q - SPEED_V;
      default: pos_d = pos_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pos_q         <= '0;
      draw_enable_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      draw_enable_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q <= S_UPDATE;
            busy_q  <= 1'b1;
          end
        end
        S_UPDATE: begin
          pos_q         <= pos_d;
          state_q       <= S_START;
          draw_enable_q <= 1'b1;
        end
        S_START: begin
          state_q <= S_ACK;
        end
        S_ACK: begin
          if (!draw_done) state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (draw_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Decoded from registers only, so it pulses in the very cycle the tick is lost.
  assign frame_overrun  = tick && (state_q != S_IDLE);

  assign draw_enable    = draw_enable_q;
  assign busy           = busy_q;
  assign x_tile_offset  = pos_q[13:3];
  assign x_pixel_offset = pos_q[2:0];
  assign at_left_end    = (pos_q == '0);
  assign at_right_end   = (pos_q == MAX_POS_V);

endmodule

// File: tb/tb_scroll_controller.sv
// Randomised frame-level bench for scroll_controller with a behavioural
// drawBackground model (done high while waiting, fixed-length draw).
module tb_scroll_controller;

  localparam int FDIV  = 16;
  localparam int SPD   = 3;
  localparam int MAXP  = (24 - 20) * 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        move_right = 1'b0;
  logic        move_left = 1'b0;
  logic        draw_done;
  logic        draw_enable;
  logic [10:0] x_tile_offset;
  logic [2:0]  x_pixel_offset;
  logic        busy;
  logic        at_left_end;
  logic        at_right_end;
  logic        frame_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int pos_m    = 0;
  int draw_len_m = 10;
  int cyc;
  int draw_cnt;

  scroll_controller #(
    .TILEMAP_LENGTH(24),
    .SCREEN_TILES  (20),
    .FRAME_DIV     (FDIV),
    .SPEED         (SPD)
  ) dut (
    .clock         (clk),
    .resetn        (rst_n),
    .move_right    (move_right),
    .move_left     (move_left),
    .draw_done     (draw_done),
    .draw_enable   (draw_enable),
    .x_tile_offset (x_tile_offset),
    .x_pixel_offset(x_pixel_offset),
    .busy          (busy),
    .at_left_end   (at_left_end),
    .at_right_end  (at_right_end),
    .frame_overrun (frame_overrun)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; a tick is due whenever this is 15 mod 16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // drawBackground stand-in: done drops on enable and rises draw_len_m cycles later.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_done <= 1'b1;
      draw_cnt  <= 0;
    end else if (draw_enable) begin
      draw_done <= 1'b0;
      draw_cnt  <= draw_len_m;
    end else if (draw_cnt > 1) begin
      draw_cnt <= draw_cnt - 1;
    end else if (draw_cnt == 1) begin
      draw_cnt  <= 0;
      draw_done <= 1'b1;
    end
  end

  function automatic int ref_next(input int p, input bit r, input bit l);
    if (r && !l) return (p + SPD > MAXP) ? MAXP : p + SPD;
    if (l && !r) return (p < SPD) ? 0 : p - SPD;
    return p;
  endfunction

  task automatic run_frame(input bit r, input bit l, input int dlen);
    int  old_pos, new_pos, flen, waited, exp_p;
    bit  exp_busy, exp_en, exp_ovr;
    int  en_pulses, ovr_pulses;
    draw_len_m = dlen;
    waited = 0;
    en_pulses = 0;
    ovr_pulses = 0;
    @(negedge clk);
    while (cyc % FDIV != FDIV - 1) begin
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_busy: busy=%0b required 0 (cyc %0d)", busy, cyc);
      end
      move_right = 1'($urandom);
      move_left  = 1'($urandom);
      waited++;
      if (waited > 40) begin
        n_fail++;
        $display("FAIL tick_timeout: no tick within 40 cycles (cyc %0d) required one", cyc);
        return;
      end
      @(negedge clk);
    end
    move_right = r;
    move_left  = l;
    old_pos = pos_m;
    new_pos = ref_next(old_pos, r, l);
    pos_m   = new_pos;
    flen    = (dlen + 3 <= FDIV) ? FDIV : 2 * FDIV;
    for (int k = 0; k < flen; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 2) begin
        move_right = 1'($urandom);
        move_left  = 1'($urandom);
      end
      exp_p    = (k >= 2) ? new_pos : old_pos;
      exp_busy = (k >= 1) && (k <= dlen + 2);
      exp_en   = (k == 2);
      exp_ovr  = exp_busy && (k > 0) && (k % FDIV == 0);
      if (draw_enable === 1'b1) en_pulses++;
      if (frame_overrun === 1'b1) ovr_pulses++;
      n_checks++;
      if (int'(x_tile_offset) !== exp_p / 8 || int'(x_pixel_offset) !== exp_p % 8) begin
        n_fail++;
        $display("FAIL offsets k=%0d: tile=%0d pix=%0d required tile=%0d pix=%0d",
                 k, x_tile_offset, x_pixel_offset, exp_p / 8, exp_p % 8);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy k=%0d: got %0b required %0b", k, busy, exp_busy);
      end
      n_checks++;
      if (draw_enable !== exp_en) begin
        n_fail++;
        $display("FAIL draw_enable k=%0d: got %0b required %0b", k, draw_enable, exp_en);
      end
      n_checks++;
      if (frame_overrun !== exp_ovr) begin
        n_fail++;
        $display("FAIL frame_overrun k=%0d: got %0b required %0b", k, frame_overrun, exp_ovr);
      end
      n_checks++;
      if (at_left_end !== (exp_p == 0) || at_right_end !== (exp_p == MAXP)) begin
        n_fail++;
        $display("FAIL ends k=%0d: left=%0b right=%0b required left=%0b right=%0b",
                 k, at_left_end, at_right_end, exp_p == 0, exp_p == MAXP);
      end
    end
    n_checks++;
    if (en_pulses != 1) begin
      n_fail++;
      $display("FAIL enable_count: %0d pulses required 1", en_pulses);
    end
    $display("frame r=%0b l=%0b draw=%0d: pos %0d -> %0d, overruns %0d",
             r, l, dlen, old_pos, new_pos, ovr_pulses);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    move_right = 1'b0;
    move_left  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (draw_enable !== 1'b0 || busy !== 1'b0 || frame_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: en=%0b busy=%0b ovr=%0b required 0 0 0",
               draw_enable, busy, frame_overrun);
    end
    n_checks++;
    if (at_left_end !== 1'b1 || at_right_end !== 1'b0 ||
        x_tile_offset !== 11'd0 || x_pixel_offset !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_pos: left=%0b right=%0b tile=%0d pix=%0d required 1 0 0 0",
               at_left_end, at_right_end, x_tile_offset, x_pixel_offset);
    end
    #2 rst_n = 1'b1;
    pos_m = 0;
    $display("reset released");
  endtask

  task automatic test_first_frame();
    run_frame(1'b0, 1'b0, 10);
  endtask

  task automatic test_right_clamp();
    for (int i = 0; i < 12; i++) run_frame(1'b1, 1'b0, 10);
  endtask

  task automatic test_left_floor();
    for (int i = 0; i < 10; i++) run_frame(1'b0, 1'b1, 10);
    run_frame(1'b0, 1'b1, 10);
    run_frame(1'b1, 1'b1, 10);
  endtask

  task automatic test_overrun();
    run_frame(1'b1, 1'b0, 20);
    run_frame(1'b0, 1'b0, 10);
  endtask

  task automatic test_ignore_moves();
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 10);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) run_frame(1'($urandom), 1'($urandom), 10);
  endtask

  task automatic reset_during(input int kr);
    int waited;
    waited = 0;
    move_right = 1'b0;
    move_left  = 1'b0;
    draw_len_m = 10;
    @(negedge clk);
    while (cyc % FDIV != FDIV - 1 && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    n_checks++;
    if (waited >= 40) begin
      n_fail++;
      $display("FAIL reset_tick_timeout: no tick within 40 cycles required one");
    end
    for (int k = 1; k <= kr; k++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || draw_enable !== (kr == 2)) begin
      n_fail++;
      $display("FAIL pre_reset k=%0d: busy=%0b en=%0b required 1 %0b",
               kr, busy, draw_enable, kr == 2);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (draw_enable !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset k=%0d: en=%0b busy=%0b required 0 0", kr, draw_enable, busy);
    end
    n_checks++;
    if (x_tile_offset !== 11'd0 || x_pixel_offset !== 3'd0 || at_left_end !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_pos k=%0d: tile=%0d pix=%0d left=%0b required 0 0 1",
               kr, x_tile_offset, x_pixel_offset, at_left_end);
    end
    pos_m = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int j = 1; j < FDIV - 1; j++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || draw_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle j=%0d: busy=%0b en=%0b required 0 0", j, busy, draw_enable);
      end
    end
    $display("reset asserted at frame cycle %0d", kr);
    run_frame(1'b0, 1'b0, 10);
  endtask

  task automatic test_reset_mid();
    run_frame(1'b1, 1'b0, 10);
    run_frame(1'b1, 1'b0, 10);
    reset_during(2);
    run_frame(1'b1, 1'b0, 10);
    reset_during(6);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_right_clamp();
    test_left_floor();
    test_overrun();
    test_ignore_moves();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
